// File: rtl/decode_stage.sv
// Instruction-decode stage: drives register-file read addresses and captures
// decoded operands into the ID/EX register with stall, flush and bypass.
module decode_stage #(
   parameter int          CNT_W   = 16,
   parameter logic [5:0]  R_OPC   = 6'b100000,
   parameter logic [5:0]  LW_OPC  = 6'b001111,
   parameter logic [5:0]  SW_OPC  = 6'b011111,
   parameter logic [5:0]  BEQ_OPC = 6'b010000
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             InstrValid,
   input  logic [31:0]      Instr,
   output logic             InstrReady,
   output logic [4:0]       Adr1,
   output logic [4:0]       Adr2,
   input  logic [31:0]      Dout1,
   input  logic [31:0]      Dout2,
   input  logic             WbWrEn,
   input  logic [4:0]       WbAwr,
   input  logic [31:0]      WbDin,
   input  logic             Flush,
   input  logic             ExReady,
   output logic             ExValid,
   output logic [5:0]       ExOp,
   output logic [31:0]      ExA,
   output logic [31:0]      ExB,
   output logic [31:0]      ExImm,
   output logic [4:0]       ExAwr,
   output logic             ExWrEn,
   output logic             ExIsLoad,
   output logic [CNT_W-1:0] StallCount
);

   logic [5:0]  op;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic        reads_rt, hazard, adv, accept;
   logic [4:0]  dst;
   logic        wr_en;
   logic [31:0] opa, opb;

   assign op  = Instr[31:26];
   assign rs  = Instr[25:21];
   assign rt  = Instr[20:16];
   assign rd  = Instr[15:11];
   assign imm = Instr[15:0];

   assign Adr1 = rs;
   assign Adr2 = rt;

   assign reads_rt = (op == R_OPC) | (op == SW_OPC) | (op == BEQ_OPC);
   assign hazard   = ExValid & ExIsLoad &
                     ((ExAwr == rs) | ((ExAwr == rt) & reads_rt));

   assign adv        = !ExValid | ExReady;
   assign InstrReady = Flush | (adv & !hazard);
   assign accept     = InstrValid & InstrReady & !Flush;

   // Forward the write-back value so a same-cycle write is seen on capture
   assign opa = (WbWrEn && WbAwr == rs) ? WbDin : Dout1;
   assign opb = (WbWrEn && WbAwr == rt) ? WbDin : Dout2;

   always_comb begin
      dst   = rt;
      wr_en = 1'b1;
      unique case (1'b1)
         (op == R_OPC):   dst = rd;
         (op == SW_OPC),
         (op == BEQ_OPC): wr_en = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ExValid  <= 1'b0;
         ExOp     <= '0;
         ExA      <= '0;
         ExB      <= '0;
         ExImm    <= '0;
         ExAwr    <= '0;
         ExWrEn   <= 1'b0;
         ExIsLoad <= 1'b0;
      end else if (Flush) begin
         ExValid <= 1'b0;
      end else if (adv) begin
         ExValid <= accept;
         if (accept) begin
            ExOp     <= op;
            ExA      <= opa;
            ExB      <= opb;
            ExImm    <= {{16{imm[15]}}, imm};
            ExAwr    <= dst;
            ExWrEn   <= wr_en;
            ExIsLoad <= (op == LW_OPC);
         end
      end
   end

   // Bubble counter saturates instead of wrapping
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         StallCount <= '0;
      else if (InstrValid & hazard & adv & !Flush & ~&StallCount)
         StallCount <= StallCount + 1'b1;
   end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage against a behavioural
// model of the ID/EX register contents and the bubble counter.
module tb_decode_stage;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam logic [5:0] R_OPC   = 6'b100000;
   localparam logic [5:0] LW_OPC  = 6'b001111;
   localparam logic [5:0] SW_OPC  = 6'b011111;
   localparam logic [5:0] BEQ_OPC = 6'b010000;

   logic             Clk, Rst;
   logic             InstrValid, InstrReady;
   logic [31:0]      Instr;
   logic [4:0]       Adr1, Adr2;
   logic [31:0]      Dout1, Dout2;
   logic             WbWrEn;
   logic [4:0]       WbAwr;
   logic [31:0]      WbDin;
   logic             Flush, ExReady, ExValid;
   logic [5:0]       ExOp;
   logic [31:0]      ExA, ExB, ExImm;
   logic [4:0]       ExAwr;
   logic             ExWrEn, ExIsLoad;
   logic [CNT_W-1:0] StallCount;

   decode_stage #(.CNT_W(CNT_W)) dut (
      .Clk(Clk), .Rst(Rst),
      .InstrValid(InstrValid), .Instr(Instr), .InstrReady(InstrReady),
      .Adr1(Adr1), .Adr2(Adr2), .Dout1(Dout1), .Dout2(Dout2),
      .WbWrEn(WbWrEn), .WbAwr(WbAwr), .WbDin(WbDin),
      .Flush(Flush), .ExReady(ExReady), .ExValid(ExValid),
      .ExOp(ExOp), .ExA(ExA), .ExB(ExB), .ExImm(ExImm),
      .ExAwr(ExAwr), .ExWrEn(ExWrEn), .ExIsLoad(ExIsLoad),
      .StallCount(StallCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_tests = 0;
   int n_fail  = 0;

   bit          m_valid, m_wren, m_load;
   logic [5:0]  m_op;
   logic [31:0] m_a, m_b, m_imm;
   logic [4:0]  m_awr;
   int          m_cnt;
   bit          last_rdy;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input int rs,
                                      input int rt, input int rd,
                                      input logic [10:0] lo);
      return {op, 5'(rs), 5'(rt), 5'(rd), lo};
   endfunction

   function automatic logic [31:0] mki(input logic [5:0] op, input int rs,
                                       input int rt, input logic [15:0] im);
      return {op, 5'(rs), 5'(rt), im};
   endfunction

   task automatic model_reset();
      m_valid = 0; m_wren = 0; m_load = 0; m_op = 0;
      m_a = 0; m_b = 0; m_imm = 0; m_awr = 0; m_cnt = 0;
   endtask

   task automatic chk_outs(input string t);
      chk({t, "_valid"}, 32'(ExValid), 32'(m_valid));
      chk({t, "_cnt"}, 32'(StallCount), 32'(m_cnt));
      if (m_valid) begin
         chk({t, "_op"}, 32'(ExOp), 32'(m_op));
         chk({t, "_a"}, ExA, m_a);
         chk({t, "_b"}, ExB, m_b);
         chk({t, "_imm"}, ExImm, m_imm);
         chk({t, "_awr"}, 32'(ExAwr), 32'(m_awr));
         chk({t, "_wren"}, 32'(ExWrEn), 32'(m_wren));
         chk({t, "_load"}, 32'(ExIsLoad), 32'(m_load));
      end
   endtask

   task automatic step(input logic iv, input logic [31:0] ins,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic wwe, input logic [4:0] wa,
                       input logic [31:0] wd, input logic fl,
                       input logic er);
      logic [5:0] op;
      logic [4:0] rs, rt, rd;
      bit uses_rt, haz, adv, rdy, acc;
      InstrValid = iv; Instr = ins; Dout1 = d1; Dout2 = d2;
      WbWrEn = wwe; WbAwr = wa; WbDin = wd; Flush = fl; ExReady = er;
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      uses_rt = (op == R_OPC) || (op == SW_OPC) || (op == BEQ_OPC);
      haz = m_valid && m_load &&
            (m_awr == rs || (m_awr == rt && uses_rt));
      adv = !m_valid || er;
      rdy = fl || (adv && !haz);
      acc = iv && rdy && !fl;
      #1;
      last_rdy = InstrReady;
      chk("rdy", 32'(InstrReady), 32'(rdy));
      chk("adr1", 32'(Adr1), 32'(rs));
      chk("adr2", 32'(Adr2), 32'(rt));
      @(posedge Clk);
      if (iv && haz && adv && !fl && m_cnt < CMAX) m_cnt++;
      if (fl) m_valid = 0;
      else if (adv) begin
         m_valid = acc;
         if (acc) begin
            m_op   = op;
            m_a    = (wwe && wa == rs) ? wd : d1;
            m_b    = (wwe && wa == rt) ? wd : d2;
            m_imm  = 32'($signed(ins[15:0]));
            m_awr  = (op == R_OPC) ? rd : rt;
            m_wren = !(op == SW_OPC || op == BEQ_OPC);
            m_load = (op == LW_OPC);
         end
      end
      #1;
      chk_outs("step");
   endtask

   task automatic go(input logic [31:0] ins, input logic [31:0] d1,
                     input logic er);
      step(1'b1, ins, d1, d1 ^ 32'h0f0f, 1'b0, 5'd0, 32'h0, 1'b0, er);
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [5:0] op;
      case ($urandom_range(0, 5))
         0, 1:    op = LW_OPC;
         2:       op = R_OPC;
         3:       op = SW_OPC;
         4:       op = BEQ_OPC;
         default: op = 6'($urandom);
      endcase
      return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 11'($urandom)};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] lw, dep, nxt, held_a;
      Rst = 1'b1; InstrValid = 0; Instr = 0; Dout1 = 0; Dout2 = 0;
      WbWrEn = 0; WbAwr = 0; WbDin = 0; Flush = 0; ExReady = 0;
      model_reset();
      #2;
      chk_outs("rst0");
      chk("rst0_cnt0", 32'(StallCount), 32'd0);
      @(posedge Clk); #1; Rst = 1'b0;

      go(mk(R_OPC, 1, 2, 3, 11'h0), 32'd5, 1'b1);
      chk("r_valid", 32'(ExValid), 1);
      chk("r_a", ExA, 32'd5);
      chk("r_awr", 32'(ExAwr), 3);
      chk("r_wren", 32'(ExWrEn), 1);
      chk("r_load", 32'(ExIsLoad), 0);

      step(1, mk(R_OPC, 0, 5, 6, 11'h0), 0, 9, 1, 5'd0, 32'h2232, 0, 1);
      chk("byp_on", ExA, 32'h2232);
      step(1, mk(R_OPC, 0, 5, 6, 11'h0), 0, 9, 0, 5'd0, 32'h2232, 0, 1);
      chk("byp_off", ExA, 32'h0);

      lw  = mki(LW_OPC, 0, 4, 16'h0010);
      dep = mk(R_OPC, 4, 1, 2, 11'h0);
      go(lw, 32'h10, 1'b1);
      go(dep, 32'h11, 1'b1);
      chk("lu_rdy", 32'(last_rdy), 0);
      chk("lu_bubble", 32'(ExValid), 0);
      chk("lu_cnt", 32'(StallCount), 1);
      go(dep, 32'h12, 1'b1);
      chk("lu_rdy2", 32'(last_rdy), 1);
      chk("lu_cap", ExA, 32'h12);

      go(mki(LW_OPC, 0, 4, 16'hFFFC), 32'h20, 1'b1);
      chk("lu_imm", ExImm, 32'hFFFFFFFC);
      go(dep, 32'h21, 1'b1);
      go(dep, 32'h22, 1'b1);
      chk("lu2_cnt", 32'(StallCount), 2);

      held_a = ExA;
      nxt = mk(R_OPC, 7, 8, 9, 11'h0);
      repeat (3) begin
         go(nxt, 32'h99, 1'b0);
         chk("bp_rdy", 32'(last_rdy), 0);
         chk("bp_hold", ExA, held_a);
         chk("bp_cnt", 32'(StallCount), 2);
      end
      go(nxt, 32'h99, 1'b1);
      chk("bp_cap", ExA, 32'h99);

      go(lw, 32'h30, 1'b1);
      step(1, dep, 32'h31, 0, 0, 5'd0, 0, 1, 0);
      chk("fl_rdy", 32'(last_rdy), 1);
      chk("fl_valid", 32'(ExValid), 0);
      chk("fl_cnt", 32'(StallCount), 2);

      go(lw, 32'h40, 1'b1);
      go(dep, 32'h41, 1'b1);
      go(dep, 32'h42, 1'b1);
      go(mk(R_OPC, 1, 2, 3, 11'h0), 32'h55, 1'b1);
      step(0, 32'h0, 0, 0, 0, 5'd0, 0, 0, 0);
      chk("pre_valid", 32'(ExValid), 1);
      chk("pre_a", ExA, 32'h55);
      chk("pre_cnt", 32'(StallCount), 3);
      #2; Rst = 1'b1; #1;
      model_reset();
      chk_outs("mrst");
      chk("mrst_a", ExA, 32'h0);
      chk("mrst_cnt", 32'(StallCount), 0);
      @(posedge Clk); #1; Rst = 1'b0;

      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 9) < 8, rnd_instr(), $urandom, $urandom,
              1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
      end
      chk("sat_cnt", 32'(StallCount), 32'(m_cnt));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage that sits directly upstream of the RegisterFile.
- Drives the register-file read addresses (Adr1/Adr2) combinationally from the incoming instruction.
- Captures the returned operands (Dout1/Dout2), decoded control and sign-extended immediate into an ID/EX pipeline register.
- Handles valid/ready backpressure, flush, write-back bypass and single-cycle load-use stall insertion, with a saturating bubble counter.

Parameters:
- CNT_W, 16, width of the StallCount bubble counter.
- R_OPC, 6'b100000, R-type opcode; destination is rd.
- LW_OPC, 6'b001111, load opcode; destination is rt; load-use hazard source.
- SW_OPC, 6'b011111, store opcode; reads rs and rt; no register write.
- BEQ_OPC, 6'b010000, branch opcode; reads rs and rt; no register write.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- InstrValid  in  1  Instr holds a valid instruction.
- Instr  in  32  instruction fields: op[31:26] rs[25:21] rt[20:16] rd[15:11] imm[15:0].
- InstrReady  out  1  stage accepts Instr this cycle.
- Adr1  out  5  register-file read address 1, equal to Instr[25:21].
- Adr2  out  5  register-file read address 2, equal to Instr[20:16].
- Dout1  in  32  register-file read data 1.
- Dout2  in  32  register-file read data 2.
- WbWrEn  in  1  write-back write enable (same signal as the register-file WrEn).
- WbAwr  in  5  write-back address.
- WbDin  in  32  write-back data.
- Flush  in  1  discard the ID/EX contents and the incoming instruction.
- ExReady  in  1  downstream stage consumes ExValid this cycle.
- ExValid  out  1  ID/EX register holds a valid instruction.
- ExOp  out  6  captured opcode.
- ExA  out  32  operand A.
- ExB  out  32  operand B.
- ExImm  out  32  sign-extended imm.
- ExAwr  out  5  destination register.
- ExWrEn  out  1  instruction writes a register.
- ExIsLoad  out  1  instruction is LW.
- StallCount  out  CNT_W  number of load-use bubbles inserted; saturates at all-ones.

Behaviour:
- Reset (Rst=1, asynchronous):
  - ExValid, ExOp, ExA, ExB, ExImm, ExAwr, ExWrEn, ExIsLoad and StallCount clear to 0 immediately, without waiting for a clock edge.
  - Mid-operation reset drops any held instruction.
- Adr1 and Adr2 are purely combinational from Instr and are valid regardless of InstrValid.
- Hazard (combinational):
  - hazard = ExValid & ExIsLoad & (ExAwr==rs | (ExAwr==rt & op∈{R_OPC,SW_OPC,BEQ_OPC})).
  - Register 0 gets no special treatment.
- Ready and accept:
  - adv = !ExValid | ExReady.
  - InstrReady = Flush | (adv & !hazard).
  - accept = InstrValid & InstrReady & !Flush.
- ID/EX register update, in priority order:
  1. Flush=1 → ExValid<=0; the incoming instruction is dropped; the data fields are don't-care.
  2. Else if adv → ExValid<=accept; when accept, load all Ex* fields. When hazard, this inserts a bubble (ExValid<=0).
  3. Else → hold every output unchanged.
- Latency: an accepted instruction appears on Ex* on the next rising edge, i.e. 1 cycle.
- Operand bypass (applied at capture):
  - ExA = (WbWrEn & WbAwr==rs) ? WbDin : Dout1.
  - ExB = (WbWrEn & WbAwr==rt) ? WbDin : Dout2.
  - This covers a register-file write and read in the same cycle.
- Decode:
  - ExAwr = rd for R_OPC, else rt.
  - ExWrEn = 0 for SW_OPC and BEQ_OPC, 1 otherwise.
  - ExIsLoad = (op==LW_OPC).
  - ExImm = {{16{imm[15]}}, imm}.
- Load-use stall: exactly one bubble cycle. On the next edge the load has left ID/EX (ExReady=1), so the hazard clears and the dependent instruction is accepted.
- StallCount:
  - Increments by 1 on each edge where InstrValid & hazard & adv & !Flush.
  - Saturates at 2^CNT_W-1 (no wrap-around).
  - Unaffected by Flush cycles.
- Simultaneous events:
  - Flush overrides both stall and backpressure.
  - ExReady=0 with hazard → hold only; no bubble is counted.

Test Plan:
- Reset mid-operation: ExValid=1, ExA=0x55, StallCount=3; pulse Rst between clock edges → all Ex* outputs and StallCount read 0 before the next edge.
- R-type capture: Instr op=100000 rs=1 rt=2 rd=3, Dout1=5, Dout2=7, InstrValid=1, ExReady=1 → after 1 edge: ExValid=1, ExA=5, ExB=7, ExAwr=3, ExWrEn=1, ExIsLoad=0; Adr1=1, Adr2=2 combinationally.
- Write-back bypass: Instr rs=0, Dout1=0, WbWrEn=1, WbAwr=0, WbDin=0x2232 → ExA=0x2232. Repeat with WbWrEn=0 → ExA=0.
- Load-use: LW rt=4 accepted, then R-type rs=4 → InstrReady=0 for exactly 1 cycle, ExValid=0 for 1 cycle (bubble), StallCount=1; the R-type is captured on the following edge. Same sequence with imm=0xFFFC → ExImm=0xFFFFFFFC.
- Backpressure: ExValid=1, ExReady=0 for 3 cycles with a new instruction waiting → Ex* unchanged, InstrReady=0, StallCount unchanged; ExReady=1 → the new instruction is captured next edge.
- Flush priority: hazard active, ExReady=0, InstrValid=1, Flush=1 → InstrReady=1; after the edge ExValid=0, the instruction is dropped and StallCount is unchanged.
